// File: rtl/fifo_sync_gen2_pkg.sv
// Shared FIFO definitions: default geometry and read-mode constants used by
// this FIFO and the later multi-channel FIFOs.
package fifo_sync_gen2_pkg;

  localparam int DEF_DATA_SIZE = 12;
  localparam int DEF_ADDR_SIZE = 3;

  // Read-mode selectors for the FWFT parameter.
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Occupancy-window test shared by the almost_empty flag of every FIFO flavour.
  function automatic logic in_low_window(input logic [7:0] cnt, input logic [7:0] th);
    return (cnt != 8'd0) && (cnt <= th);
  endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Storage array: one synchronous write port and one asynchronous read port.
module fifo_dp_ram #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem_q [2**ADDR_SIZE];

  // NOTE: the array has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_gen2.sv
// Single-clock FIFO with run-time almost thresholds, sticky error reporting
// and a choice of registered or first-word-fall-through read.
module fifo_sync_gen2
  import fifo_sync_gen2_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int FWFT      = FIFO_STD
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 err_clr,
  input  logic [ADDR_SIZE:0]   th_almost_full,
  input  logic [ADDR_SIZE:0]   th_almost_empty,
  output logic [DATA_SIZE-1:0] fifo_data_out,
  output logic                 data_valid,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 fifo_error,
  output logic [ADDR_SIZE:0]   count
);

  localparam logic [ADDR_SIZE:0] DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [ADDR_SIZE-1:0] ptr_wr_q, ptr_wr_d;
  logic [ADDR_SIZE-1:0] ptr_rd_q, ptr_rd_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 err_q, err_d;
  logic                 wr_ok, rd_ok;
  logic [DATA_SIZE-1:0] ram_rdata;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == DEPTH);
  assign almost_full  = (count_q >= th_almost_full);
  assign almost_empty = in_low_window(8'(count_q), 8'(th_almost_empty));
  assign count        = count_q;
  assign fifo_error   = err_q;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign wr_ok     = write && (!fifo_full || read);
  assign rd_ok     = read && !fifo_empty;
  assign overflow  = write && !wr_ok;
  assign underflow = read && !rd_ok;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    ptr_wr_d = ptr_wr_q;
    ptr_rd_d = ptr_rd_q;
    count_d  = count_q;
    err_d    = err_q;
    if (wr_ok) ptr_wr_d = ptr_wr_q + 1'b1;
    if (rd_ok) ptr_rd_d = ptr_rd_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (err_clr)               err_d = 1'b0;
    if (overflow || underflow) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (!reset_L) begin
      ptr_wr_q <= '0;
      ptr_rd_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_wr_q <= ptr_wr_d;
      ptr_rd_q <= ptr_rd_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  fifo_dp_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok && reset_L),
    .waddr(ptr_wr_q),
    .wdata(data_in),
    .raddr(ptr_rd_q),
    .rdata(ram_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign fifo_data_out = ram_rdata;
    assign data_valid    = !fifo_empty;
  end else begin : g_std
    logic [DATA_SIZE-1:0] dout_q;
    logic                 valid_q;

    always_ff @(posedge clk) begin
      if (!reset_L) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) dout_q <= ram_rdata;
      end
    end

    assign fifo_data_out = dout_q;
    assign data_valid    = valid_q;
  end

endmodule
